note_matrix_scan: RTL and testbench
===================================

Name: note_matrix_scan

Overview:
- Downstream consumer of the note shifter (note_R / note_B / offset / finish).
- Keeps a scrolling frame of ROWS x COLS red/blue pixels. A new top row of notes is pushed in each time the shifter's pixel offset changes.
- Scans the frame one row at a time into serial-in/parallel-out LED driver chips, using a data/clock/latch interface and an output-enable.

Parameters:
- ROWS, 8: display rows in the frame (row-select bits per word).
- COLS, 10: note lanes per colour; must match the note_R/note_B width.
- CLK_DIV, 4: clk cycles per ser_clk half-period (>=1).
- DWELL, 256: clk cycles a latched row stays lit (>=1).

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- note_R, in, COLS: red lane bits of the current note slice.
- note_B, in, COLS: blue lane bits of the current note slice.
- offset, in, 4: pixel counter from the shifter; any change = one scroll step.
- finish, in, 1: song-end indication; clears the frame.
- ser_data, out, 1: serial bit to the driver chain.
- ser_clk, out, 1: shift clock; data is sampled by the drivers on its rising edge.
- ser_latch, out, 1: one-cycle storage-register latch pulse.
- oe_n, out, 1: active-low driver output enable.
- row_idx, out, 3: row currently being loaded/shifted (0..ROWS-1).
- frame_tick, out, 1: one-cycle pulse when the row ROWS-1 dwell ends.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE; all frame rows=0; offset_q=0.
  - ser_data=0, ser_clk=0, ser_latch=0, oe_n=1, row_idx=0, frame_tick=0.
  - Reset mid-shift aborts immediately. No partial latch is issued.
- Scroll:
  - step = (offset != offset_q). offset_q <= offset every cycle.
  - On step: row[k] <= row[k-1] for k=ROWS-1..1, and row[0] <= {note_R, note_B}. Row ROWS-1 is discarded.
  - finish high: all rows <= 0 that cycle. finish has priority over step.
- Scan state machine IDLE -> LOAD -> SHIFT -> LATCH -> DWELL -> LOAD:
  - IDLE: one cycle, then LOAD.
  - LOAD (1 cycle):
    - word <= {row[row_idx].B[COLS-1:0], row[row_idx].R[COLS-1:0], sel}.
    - sel is ROWS bits, one-cold: bit row_idx = 0, all others 1.
    - N = 2*COLS+ROWS (28 at defaults).
    - The pre-update register value is captured. A step in the same cycle affects only later LOADs.
  - SHIFT, per bit, MSB first:
    - ser_data = current word MSB, held for the full bit.
    - ser_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - Word shifts left at the end of the bit.
    - After N bits (N*2*CLK_DIV cycles), ser_clk=0 and go to LATCH.
    - oe_n stays at its prior value during SHIFT, so the previous row remains lit.
  - LATCH (1 cycle): oe_n=1, ser_latch=1.
  - DWELL: oe_n=0 for DWELL cycles. On the last cycle:
    - row_idx <= (row_idx==ROWS-1) ? 0 : row_idx+1.
    - frame_tick=1 when the wrapped row was ROWS-1.
  - First row after reset: oe_n stays 1 until the first DWELL.
- Timing:
  - Row period = 1 + N*2*CLK_DIV + 1 + DWELL = 482 cycles at defaults.
  - Frame period = ROWS * row period = 3856 cycles.
- Frame updates never stall the scan. A row shows frame contents as of its LOAD cycle.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset values: assert rst 3 cycles -> oe_n=1, ser_clk=0, ser_latch=0, row_idx=0, frame_tick=0. First ser_clk rise occurs 1+1+CLK_DIV=6 cycles after rst release.
- Empty frame shift: no step after reset, capture 28 bits on ser_clk rises for row 0 -> B=0, R=0, sel=8'hFE. ser_latch pulses once, 1+1+224=226 cycles after rst release.
- Scroll insert: note_R=10'h201, note_B=10'h0F0, offset 0->1 -> next row-0 scan shifts B=0011110000, R=1000000001, sel=11111110. Seven further steps (offset 1..7, new notes = 0) -> row 7 holds that pattern and row 0 shows zeros.
- Simultaneous step+finish: change offset and assert finish in the same cycle -> all rows read back zero on the next full frame scan.
- Frame wrap: run 8 row periods -> row_idx sequence 0..7,0. frame_tick is a single-cycle pulse exactly at the 7->0 transition, cycle 3856 after the first LOAD.
- Reset mid-shift: assert rst during bit 10 of row 3 -> no ser_latch for that row, outputs return to reset values next cycle, scan restarts at row_idx=0 with a cleared frame.

Source files
------------

// File: rtl/note_matrix_scan.sv
// Scrolling ROWS x COLS red/blue note frame, scanned one row at a time
// into serial-in/parallel-out LED drivers over a data/clock/latch/OE link.
module note_matrix_scan #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 10,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DWELL   = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] note_R,
  input  logic [COLS-1:0] note_B,
  input  logic [3:0]      offset,
  input  logic            finish,
  output logic            ser_data,
  output logic            ser_clk,
  output logic            ser_latch,
  output logic            oe_n,
  output logic [2:0]      row_idx,
  output logic            frame_tick
);

  localparam int unsigned PIX_W  = 2 * COLS;
  localparam int unsigned WORD_W = PIX_W + ROWS;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(WORD_W);
  localparam int unsigned DWL_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_t;

  // Each row is stored as {red lanes, blue lanes}.
  logic [PIX_W-1:0]  frame [ROWS];
  logic [3:0]        offset_q;
  logic              step_c;

  logic [PIX_W-1:0]  row_c;
  logic [ROWS-1:0]   sel_c;
  logic [WORD_W-1:0] load_word_c;

  state_t            state;
  logic [WORD_W-1:0] word;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DWL_W-1:0]  dwell_cnt;

  assign step_c = (offset != offset_q);

  // Frame store: song end clears everything and wins over a scroll step.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      for (int k = 0; k < ROWS; k++) begin
        frame[k] <= '0;
      end
    end else begin
      offset_q <= offset;
      if (finish) begin
        for (int k = 0; k < ROWS; k++) begin
          frame[k] <= '0;
        end
      end else if (step_c) begin
        for (int k = ROWS - 1; k > 0; k--) begin
          frame[k] <= frame[k-1];
        end
        frame[0] <= {note_R, note_B};
      end
    end
  end

  // Shift word for the current row: blue lanes, red lanes, one-cold row select.
  assign row_c       = frame[row_idx];
  assign sel_c       = ~(ROWS'(1) << row_idx);
  assign load_word_c = {row_c[COLS-1:0], row_c[PIX_W-1:COLS], sel_c};

  // Scan sequencer; oe_n is left alone through LOAD/SHIFT so the last row stays lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      word       <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      dwell_cnt  <= '0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
      ser_latch  <= 1'b0;
      oe_n       <= 1'b1;
      row_idx    <= '0;
      frame_tick <= 1'b0;
    end else begin
      ser_latch  <= 1'b0;
      frame_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_LOAD;
        end

        S_LOAD: begin
          word     <= load_word_c;
          ser_data <= load_word_c[WORD_W-1];
          ser_clk  <= 1'b0;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= S_SHIFT;
        end

        S_SHIFT: begin
          if (div_cnt != DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else begin
              ser_clk <= 1'b0;
              word    <= word << 1;
              if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                ser_data  <= 1'b0;
                ser_latch <= 1'b1;
                oe_n      <= 1'b1;
                state     <= S_LATCH;
              end else begin
                bit_cnt  <= bit_cnt + BIT_W'(1);
                ser_data <= word[WORD_W-2];
              end
            end
          end
        end

        S_LATCH: begin
          oe_n      <= 1'b0;
          dwell_cnt <= '0;
          state     <= S_DWELL;
        end

        S_DWELL: begin
          if (dwell_cnt == DWL_W'(DWELL - 1)) begin
            dwell_cnt <= '0;
            state     <= S_LOAD;
            if (row_idx == IDX_W'(ROWS - 1)) begin
              row_idx    <= '0;
              frame_tick <= 1'b1;
            end else begin
              row_idx <= row_idx + IDX_W'(1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWL_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_matrix_scan.sv
// Directed bench for note_matrix_scan: reset, row words, scrolling, clear,
// frame wrap timing and reset in the middle of a shift.
module tb_note_matrix_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] note_R;
  logic [9:0] note_B;
  logic [3:0] offset;
  logic       finish;
  logic       ser_data;
  logic       ser_clk;
  logic       ser_latch;
  logic       oe_n;
  logic [2:0] row_idx;
  logic       frame_tick;

  note_matrix_scan dut (
    .clk        (clk),
    .rst        (rst),
    .note_R     (note_R),
    .note_B     (note_B),
    .offset     (offset),
    .finish     (finish),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .oe_n       (oe_n),
    .row_idx    (row_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycles since reset release: k after the k-th edge with rst low.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Serial link monitor: rebuild each latched word from ser_clk rises.
  logic        prev_sclk = 1'b0;
  logic [27:0] sh = '0;
  int          nb = 0;
  int          first_rise = -1;
  int          tick_cnt = 0;
  int          tick_cyc0 = 0;
  int          tick_row0 = -1;
  int          tick_wide = 0;
  bit          tick_prev = 1'b0;
  bit          oe_early = 1'b0;
  logic [27:0] lat_word[$];
  int          lat_row[$];
  int          lat_cyc[$];
  int          lat_nb[$];

  always @(negedge clk) begin
    if (rst) begin
      nb         = 0;
      sh         = '0;
      prev_sclk  = 1'b0;
      first_rise = -1;
      tick_prev  = 1'b0;
    end else begin
      if (ser_clk && !prev_sclk) begin
        sh = {sh[26:0], ser_data};
        nb++;
        if (first_rise < 0) first_rise = cyc;
      end
      prev_sclk = ser_clk;
      if (ser_latch) begin
        lat_word.push_back(sh);
        lat_row.push_back(int'(row_idx));
        lat_cyc.push_back(cyc);
        lat_nb.push_back(nb);
        nb = 0;
      end
      if (frame_tick) begin
        if (tick_prev) tick_wide++;
        tick_cnt++;
        if (tick_cnt == 1) begin
          tick_cyc0 = cyc;
          tick_row0 = int'(row_idx);
        end
      end
      tick_prev = frame_tick;
      if (!oe_n && cyc < 227) oe_early = 1'b1;
    end
  end

  function automatic logic [27:0] exp_word(input logic [9:0] r, input logic [9:0] b, input int row);
    logic [7:0] s;
    s      = 8'hFF;
    s[row] = 1'b0;
    return {b, r, s};
  endfunction

  task automatic wait_latch(input int idx);
    int t;
    t = 0;
    while (lat_word.size() <= idx && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check($sformatf("latch_seen%0d", idx), 64'(lat_word.size() > idx), 64'd1);
  endtask

  task automatic check_row(input int idx, input logic [27:0] w, input int row);
    wait_latch(idx);
    if (lat_word.size() > idx) begin
      check($sformatf("word%0d", idx), 64'(lat_word[idx]), 64'(w));
      check($sformatf("row%0d", idx), 64'(lat_row[idx]), 64'(row));
      check($sformatf("bits%0d", idx), 64'(lat_nb[idx]), 64'd28);
    end
  endtask

  task automatic step(input logic [9:0] r, input logic [9:0] b, input logic fin);
    @(posedge clk);
    #1;
    note_R = r;
    note_B = b;
    finish = fin;
    offset = offset + 4'd1;
    @(posedge clk);
    #1;
    note_R = '0;
    note_B = '0;
    finish = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_oe_n"},       64'(oe_n),       64'd1);
    check({pfx, "_ser_clk"},    64'(ser_clk),    64'd0);
    check({pfx, "_ser_latch"},  64'(ser_latch),  64'd0);
    check({pfx, "_ser_data"},   64'(ser_data),   64'd0);
    check({pfx, "_row_idx"},    64'(row_idx),    64'd0);
    check({pfx, "_frame_tick"}, 64'(frame_tick), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t;
    bit  hit;
    int  n_lat;

    rst    = 1'b1;
    note_R = '0;
    note_B = '0;
    offset = '0;
    finish = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Empty frame, row 0: first rise after IDLE+LOAD+CLK_DIV, latch after 28 bits.
    check_row(0, exp_word(10'h000, 10'h000, 0), 0);
    check("first_rise", 64'(first_rise), 64'd6);
    if (lat_cyc.size() > 0) check("latch_cyc0", 64'(lat_cyc[0]), 64'd226);
    check("oe_latch0", 64'(oe_n), 64'd1);

    // Insert a note slice while row 0 dwells; it shows on the next row-0 scan.
    step(10'h201, 10'h0F0, 1'b0);
    check("oe_dwell0", 64'(oe_n), 64'd0);
    check("oe_first_row", 64'(oe_early), 64'd0);

    for (int i = 1; i < 8; i++) check_row(i, exp_word(10'h000, 10'h000, i), i);
    if (lat_cyc.size() > 7) check("latch_cyc7", 64'(lat_cyc[7]), 64'd3600);
    check_row(8, exp_word(10'h201, 10'h0F0, 0), 0);
    if (lat_cyc.size() > 8) check("latch_cyc8", 64'(lat_cyc[8]), 64'd4082);
    check("tick_count1", 64'(tick_cnt), 64'd1);
    check("tick_cyc", 64'(tick_cyc0), 64'd3857);
    check("tick_row", 64'(tick_row0), 64'd0);

    // Seven empty steps push the pattern down to row 7.
    for (int i = 0; i < 7; i++) step(10'h000, 10'h000, 1'b0);
    for (int i = 9; i < 15; i++) check_row(i, exp_word(10'h000, 10'h000, i - 8), i - 8);
    check_row(15, exp_word(10'h201, 10'h0F0, 7), 7);
    check_row(16, exp_word(10'h000, 10'h000, 0), 0);

    // Fill some rows, then step and finish together: frame must come back empty.
    step(10'h155, 10'h2AA, 1'b0);
    step(10'h3FF, 10'h001, 1'b0);
    step(10'h0AA, 10'h155, 1'b0);
    step(10'h3FF, 10'h3FF, 1'b1);
    for (int i = 17; i < 24; i++) check_row(i, exp_word(10'h000, 10'h000, i - 16), i - 16);
    check_row(24, exp_word(10'h000, 10'h000, 0), 0);

    // Dirty row 0, then reset during bit 10 of row 3.
    step(10'h3FF, 10'h3FF, 1'b0);
    check_row(25, exp_word(10'h000, 10'h000, 1), 1);
    check_row(26, exp_word(10'h000, 10'h000, 2), 2);
    t   = 0;
    hit = 1'b0;
    while (!hit && t < 1000) begin
      @(posedge clk);
      if (row_idx == 3'd3 && nb == 10 && !ser_clk) hit = 1'b1;
      t++;
    end
    check("midshift_found", 64'(hit), 64'd1);
    #1 rst = 1'b1;
    n_lat = lat_word.size();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    check("no_partial_latch", 64'(lat_word.size()), 64'd27);
    check("latch_count_hold", 64'(lat_word.size()), 64'(n_lat));
    @(posedge clk);
    #1 rst = 1'b0;

    // Scan restarts at row 0 with the cleared frame.
    check_row(27, exp_word(10'h000, 10'h000, 0), 0);
    if (lat_cyc.size() > 27) check("latch_cyc_restart", 64'(lat_cyc[27]), 64'd226);
    check("first_rise_restart", 64'(first_rise), 64'd6);
    check("tick_count_final", 64'(tick_cnt), 64'd3);
    check("tick_single_cycle", 64'(tick_wide), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
